// File: rtl/ext_mem_arbiter.sv
// Single-port external frame memory arbiter for write-back, reference fetch and display bursts.
// Optional EXT_ARB_PERF_CNT_EN adds busy-cycle and urgent-grant performance counters.
module ext_mem_arbiter #(
    parameter int unsigned AW = 26,
    parameter int unsigned LW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [LW-1:0] wr_len_i,
    input  logic [31:0]   wr_data_i,
    output logic          wr_gnt_o,
    output logic          wr_beat_ack_o,
    input  logic          rd_req_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [LW-1:0] rd_len_i,
    output logic          rd_gnt_o,
    output logic [63:0]   rd_data_o,
    output logic          rd_valid_o,
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    input  logic [LW-1:0] disp_len_i,
    input  logic          disp_urgent_i,
    output logic          disp_gnt_o,
    output logic [63:0]   disp_data_o,
    output logic          disp_valid_o,
    output logic          mem_wr_o,
    output logic [AW-1:0] mem_wr_addr_o,
    output logic [31:0]   mem_wr_data_o,
    output logic [AW-1:0] mem_rd_addr_o,
    input  logic [63:0]   mem_rd_data_i,
    output logic          busy_o
`ifdef EXT_ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_busy_cnt_o,
    output logic [31:0]   perf_urgent_cnt_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DISP} state_e;
    typedef enum logic [1:0] {SRC_WR = 2'd0, SRC_RD = 2'd1, SRC_DISP = 2'd2} src_e;

    state_e        state_q, state_d;
    src_e          ptr_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] cnt_q;
    logic          wr_gnt_q, rd_gnt_q, disp_gnt_q;
    logic          wr_gnt_d, rd_gnt_d, disp_gnt_d;
    logic          mem_wr_q, busy_q;
    logic          rd_valid_q, disp_valid_q;

    logic [2:0]    req_c;
    src_e          ord0_c, ord1_c, ord2_c;
    src_e          win_c;
    logic          win_valid_c;
    logic          urgent_win_c;

    // Round-robin search order starts just after the last granted requester
    always_comb begin
        req_c = {disp_req_i, rd_req_i, wr_req_i};
        case (ptr_q)
            SRC_WR: begin
                ord0_c = SRC_RD;
                ord1_c = SRC_DISP;
                ord2_c = SRC_WR;
            end
            SRC_RD: begin
                ord0_c = SRC_DISP;
                ord1_c = SRC_WR;
                ord2_c = SRC_RD;
            end
            default: begin
                ord0_c = SRC_WR;
                ord1_c = SRC_RD;
                ord2_c = SRC_DISP;
            end
        endcase
    end

    always_comb begin
        win_c        = SRC_WR;
        win_valid_c  = 1'b0;
        urgent_win_c = 1'b0;
        if (disp_urgent_i && disp_req_i) begin
            win_c        = SRC_DISP;
            win_valid_c  = 1'b1;
            urgent_win_c = 1'b1;
        end else if (req_c[ord0_c]) begin
            win_c       = ord0_c;
            win_valid_c = 1'b1;
        end else if (req_c[ord1_c]) begin
            win_c       = ord1_c;
            win_valid_c = 1'b1;
        end else if (req_c[ord2_c]) begin
            win_c       = ord2_c;
            win_valid_c = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant decode
    always_comb begin
        state_d    = state_q;
        wr_gnt_d   = 1'b0;
        rd_gnt_d   = 1'b0;
        disp_gnt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_valid_c) begin
                    case (win_c)
                        SRC_WR: begin
                            state_d  = S_WR;
                            wr_gnt_d = 1'b1;
                        end
                        SRC_RD: begin
                            state_d  = S_RD;
                            rd_gnt_d = 1'b1;
                        end
                        default: begin
                            state_d    = S_DISP;
                            disp_gnt_d = 1'b1;
                        end
                    endcase
                end
            end
            S_WR, S_RD, S_DISP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Burst address/beat counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= SRC_WR;
            addr_q       <= '0;
            cnt_q        <= '0;
            wr_gnt_q     <= 1'b0;
            rd_gnt_q     <= 1'b0;
            disp_gnt_q   <= 1'b0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                if (win_valid_c) begin
                    ptr_q <= win_c;
                    case (win_c)
                        SRC_WR: begin
                            addr_q <= wr_addr_i;
                            cnt_q  <= wr_len_i;
                        end
                        SRC_RD: begin
                            addr_q <= rd_addr_i;
                            cnt_q  <= rd_len_i;
                        end
                        default: begin
                            addr_q <= disp_addr_i;
                            cnt_q  <= disp_len_i;
                        end
                    endcase
                end
            end else begin
                addr_q <= addr_q + ((state_q == S_WR) ? AW'(4) : AW'(8));
                cnt_q  <= cnt_q - LW'(1);
            end
            wr_gnt_q     <= wr_gnt_d;
            rd_gnt_q     <= rd_gnt_d;
            disp_gnt_q   <= disp_gnt_d;
            mem_wr_q     <= (state_d == S_WR);
            busy_q       <= (state_d != S_IDLE);
            // Owner tag of the read issued this cycle; data returns next cycle
            rd_valid_q   <= (state_q == S_RD);
            disp_valid_q <= (state_q == S_DISP);
        end
    end

`ifdef EXT_ARB_PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_urgent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q   <= '0;
            perf_urgent_q <= '0;
        end else begin
            if (busy_q) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if ((state_q == S_IDLE) && urgent_win_c) begin
                perf_urgent_q <= perf_urgent_q + 32'd1;
            end
        end
    end

    assign perf_busy_cnt_o   = perf_busy_q;
    assign perf_urgent_cnt_o = perf_urgent_q;
`endif

    assign wr_gnt_o      = wr_gnt_q;
    assign rd_gnt_o      = rd_gnt_q;
    assign disp_gnt_o    = disp_gnt_q;
    assign wr_beat_ack_o = mem_wr_q;
    assign mem_wr_o      = mem_wr_q;
    assign mem_wr_addr_o = addr_q;
    assign mem_rd_addr_o = addr_q;
    assign busy_o        = busy_q;
    assign rd_valid_o    = rd_valid_q;
    assign disp_valid_o  = disp_valid_q;
    // Data paths are forwarded combinationally and held at zero when not valid
    assign mem_wr_data_o = mem_wr_q ? wr_data_i : 32'd0;
    assign rd_data_o     = rd_valid_q ? mem_rd_data_i : 64'd0;
    assign disp_data_o   = disp_valid_q ? mem_rd_data_i : 64'd0;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed testbench for ext_mem_arbiter with a one-cycle-latency memory read model.
module tb_ext_mem_arbiter;

    localparam int unsigned AW = 26;
    localparam int unsigned LW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, rd_req, disp_req, disp_urgent;
    logic [AW-1:0] wr_addr, rd_addr, disp_addr;
    logic [LW-1:0] wr_len, rd_len, disp_len;
    logic [31:0]   wr_data;
    logic          wr_gnt, rd_gnt, disp_gnt, wr_beat_ack;
    logic [63:0]   rd_data, disp_data;
    logic          rd_valid, disp_valid;
    logic          mem_wr;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [31:0]   mem_wr_data;
    logic [63:0]   mem_rd_data = 64'd0;
    logic          busy;
`ifdef EXT_ARB_PERF_CNT_EN
    logic [31:0]   perf_busy_cnt, perf_urgent_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ext_mem_arbiter #(.AW(AW), .LW(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_req_i      (wr_req),
        .wr_addr_i     (wr_addr),
        .wr_len_i      (wr_len),
        .wr_data_i     (wr_data),
        .wr_gnt_o      (wr_gnt),
        .wr_beat_ack_o (wr_beat_ack),
        .rd_req_i      (rd_req),
        .rd_addr_i     (rd_addr),
        .rd_len_i      (rd_len),
        .rd_gnt_o      (rd_gnt),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .disp_req_i    (disp_req),
        .disp_addr_i   (disp_addr),
        .disp_len_i    (disp_len),
        .disp_urgent_i (disp_urgent),
        .disp_gnt_o    (disp_gnt),
        .disp_data_o   (disp_data),
        .disp_valid_o  (disp_valid),
        .mem_wr_o      (mem_wr),
        .mem_wr_addr_o (mem_wr_addr),
        .mem_wr_data_o (mem_wr_data),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data),
        .busy_o        (busy)
`ifdef EXT_ARB_PERF_CNT_EN
        ,
        .perf_busy_cnt_o   (perf_busy_cnt),
        .perf_urgent_cnt_o (perf_urgent_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mdata(input logic [AW-1:0] a);
        return 64'h5A5A_0000_0000_0000 ^ {38'd0, a};
    endfunction

    // Memory model: read data for an address appears one cycle later
    always @(posedge clk) mem_rd_data <= mdata(mem_rd_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [2:0] rr_gnt_exp [7];
    logic       rr_busy_exp [7];

    initial begin
        rst_n = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; disp_req = 1'b0; disp_urgent = 1'b0;
        wr_addr = '0; rd_addr = '0; disp_addr = '0;
        wr_len = '0; rd_len = '0; disp_len = '0;
        wr_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnts", 64'({wr_gnt, rd_gnt, disp_gnt}), 64'd0);
        chk("rst_mem_wr", 64'({mem_wr, wr_beat_ack}), 64'd0);
        chk("rst_valids", 64'({rd_valid, disp_valid}), 64'd0);
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_data", rd_data | disp_data | 64'(mem_wr_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Four-beat write burst at 0x100
        wr_req = 1'b1; wr_addr = 26'h100; wr_len = 6'd3; wr_data = 32'hA0;
        tick();
        chk("wr_gnt", 64'({wr_gnt, rd_gnt, disp_gnt}), 64'b100);
        wr_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) chk("wr_gnt_pulse", 64'(wr_gnt), 64'd0);
            chk("wr_beat", 64'({mem_wr, wr_beat_ack, busy}), 64'b111);
            chk("wr_addr", 64'(mem_wr_addr), 64'(26'h100 + 26'(4 * k)));
            chk("wr_data", 64'(mem_wr_data), 64'(32'hA0 + 32'(k)));
            wr_data = 32'hA1 + 32'(k);
            tick();
        end
        chk("wr_done", 64'({mem_wr, wr_beat_ack, busy}), 64'b000);

        // Urgent display beats round-robin (RD would be next)
        wr_req = 1'b1; rd_req = 1'b1; disp_req = 1'b1; disp_urgent = 1'b1;
        disp_addr = 26'h400; disp_len = 6'd0; rd_addr = 26'h600; wr_addr = 26'h700;
        tick();
        chk("urg_gnt", 64'({wr_gnt, rd_gnt, disp_gnt}), 64'b001);
        chk("urg_rd_addr", 64'(mem_rd_addr), 64'h400);
        wr_req = 1'b0; rd_req = 1'b0; disp_req = 1'b0; disp_urgent = 1'b0;
        tick();
        chk("urg_busy", 64'(busy), 64'd0);
        chk("urg_valid", 64'({rd_valid, disp_valid}), 64'b01);
        chk("urg_data", disp_data, mdata(26'h400));
`ifdef EXT_ARB_PERF_CNT_EN
        chk("perf_urgent", 64'(perf_urgent_cnt), 64'd1);
`endif
        tick();

        // Two-beat read burst at 0x200
        rd_req = 1'b1; rd_addr = 26'h200; rd_len = 6'd1;
        tick();
        chk("rd_gnt", 64'({wr_gnt, rd_gnt, disp_gnt}), 64'b010);
        chk("rd_addr0", 64'(mem_rd_addr), 64'h200);
        chk("rd_valid_lag", 64'(rd_valid), 64'd0);
        rd_req = 1'b0;
        tick();
        chk("rd_addr1", 64'(mem_rd_addr), 64'h208);
        chk("rd_beat0", 64'({rd_valid, disp_valid}), 64'b10);
        chk("rd_data0", rd_data, mdata(26'h200));
        tick();
        chk("rd_idle", 64'(busy), 64'd0);
        chk("rd_beat1", 64'({rd_valid, disp_valid}), 64'b10);
        chk("rd_data1", rd_data, mdata(26'h208));
        tick();
        chk("rd_end", 64'({rd_valid, disp_valid}), 64'b00);

        // One-beat RD immediately followed by DISP: returns stay with their owner
        rd_req = 1'b1; rd_addr = 26'h300; rd_len = 6'd0;
        tick();
        chk("mix_rd_gnt", 64'({wr_gnt, rd_gnt, disp_gnt}), 64'b010);
        rd_req = 1'b0; disp_req = 1'b1; disp_addr = 26'h500; disp_len = 6'd1;
        tick();
        chk("mix_idle_gnt", 64'({wr_gnt, rd_gnt, disp_gnt, busy}), 64'b0000);
        chk("mix_rd_ret", 64'({rd_valid, disp_valid}), 64'b10);
        chk("mix_rd_data", rd_data, mdata(26'h300));
        tick();
        chk("mix_disp_gnt", 64'({wr_gnt, rd_gnt, disp_gnt}), 64'b001);
        chk("mix_no_ret", 64'({rd_valid, disp_valid}), 64'b00);
        disp_req = 1'b0;
        tick();
        chk("mix_disp_ret0", 64'({rd_valid, disp_valid}), 64'b01);
        chk("mix_disp_data0", disp_data, mdata(26'h500));
        tick();
        chk("mix_disp_data1", disp_data, mdata(26'h508));
        tick();
        chk("mix_end", 64'({rd_valid, disp_valid, busy}), 64'b000);

        // Reset asserted during beat 2 of an 8-beat display burst
        disp_req = 1'b1; disp_addr = 26'h800; disp_len = 6'd7;
        tick();
        chk("rb_gnt", 64'(disp_gnt), 64'd1);
        disp_req = 1'b0;
        tick();
        tick();
        chk("rb_beat2_addr", 64'(mem_rd_addr), 64'h810);
        chk("rb_beat2_valid", 64'(disp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_outs", 64'({busy, wr_gnt, rd_gnt, disp_gnt, mem_wr, rd_valid, disp_valid}), 64'd0);
        chk("rb_addr", 64'(mem_rd_addr), 64'd0);
        chk("rb_data", disp_data, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rb_quiet", 64'({busy, disp_valid}), 64'd0);
        end

        // All three held after reset: RD, DISP, WR, RD with one IDLE cycle between
        rr_gnt_exp = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b010};
        rr_busy_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        wr_req = 1'b1; rd_req = 1'b1; disp_req = 1'b1;
        wr_addr = 26'h40; rd_addr = 26'h80; disp_addr = 26'hC0;
        wr_len = 6'd0; rd_len = 6'd0; disp_len = 6'd0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("rr_gnt", 64'({wr_gnt, rd_gnt, disp_gnt}), 64'(rr_gnt_exp[k]));
            chk("rr_busy", 64'(busy), 64'(rr_busy_exp[k]));
        end
        wr_req = 1'b0; rd_req = 1'b0; disp_req = 1'b0;
        tick(); tick();

        // Write address wraps silently at 2^AW
        wr_req = 1'b1; wr_addr = 26'h3FF_FFFC; wr_len = 6'd1; wr_data = 32'h11;
        tick();
        chk("wrap_addr0", 64'(mem_wr_addr), 64'h3FF_FFFC);
        wr_req = 1'b0; wr_data = 32'h22;
        tick();
        chk("wrap_addr1", 64'(mem_wr_addr), 64'd0);
        chk("wrap_data1", 64'(mem_wr_data), 64'h22);
        tick();
        chk("wrap_done", 64'({mem_wr, busy}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_mem_arbiter.md
# ext_mem_arbiter

Single-port arbiter that shares the decoder's external frame memory among three burst requesters: reconstruction write-back (32-bit words), inter-prediction reference fetch (64-bit), and display read-out (64-bit). It sits between the decoder core / display engine and the external RAM model, and sequences one burst at a time onto the memory's write and read ports. Read data returns one cycle after the address and is routed back to the owner of that address.

## Interface
- `AW`, 26: byte address width.
- `LW`, 6: burst length field width; a burst is `len+1` beats.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `wr_req` / `rd_req` / `disp_req`  in  1 each  burst request; held until the matching gnt.
- `wr_addr` / `rd_addr` / `disp_addr`  in  AW each  burst start byte address; write start must be 4-aligned, display start 8-aligned.
- `wr_len` / `rd_len` / `disp_len`  in  LW each  beats minus one.
- `wr_gnt` / `rd_gnt` / `disp_gnt`  out  1 each  one-cycle pulse; the request is accepted.
- `disp_urgent`  in  1  display FIFO low; display wins the next arbitration.
- `wr_data`  in  32  write beat data.
- `wr_beat_ack`  out  1  `wr_data` consumed this cycle.
- `rd_data` / `disp_data`  out  64 each  returned read beat.
- `rd_valid` / `disp_valid`  out  1 each  beat valid on `rd_data` / `disp_data`.
- `mem_wr`  out  1  memory write enable.
- `mem_wr_addr`  out  AW  memory write byte address.
- `mem_wr_data`  out  32  memory write data.
- `mem_rd_addr`  out  AW  memory read byte address.
- `mem_rd_data`  in  64  memory read data; valid one cycle after `mem_rd_addr`.
- `busy`  out  1  a burst is in progress.

## Operation
- States:
  - IDLE: pick a winner, pulse its gnt, latch addr/len, then move to the matching burst state.
  - WR_BURST: one beat per cycle; drive `mem_wr=1`, `mem_wr_addr` = current address, `mem_wr_data=wr_data`, `wr_beat_ack=1`; address += 4.
  - RD_BURST / DISP_BURST: drive `mem_rd_addr` = current address; address += 8.
  - All burst states decrement the beat counter and return to IDLE after the beat where the counter is 0.
- Arbitration in IDLE:
  - `disp_urgent & disp_req` wins outright.
  - Otherwise round-robin in the order WR→RD→DISP, starting after the last granted requester. The pointer resets to WR, so RD has first priority out of reset.
- Write requester: `wr_data` must be valid on every cycle `wr_beat_ack` is high. The arbiter has no write stall.
- Read return:
  - Owner tag (none/RD/DISP) is registered with each issued read address.
  - On the next cycle, `mem_rd_data` is forwarded to `rd_data` or `disp_data` and the matching valid is asserted.
  - `rd_data` and `disp_data` are driven combinationally from `mem_rd_data`; only the valid flags are registered.
- Address arithmetic is modulo 2^AW; wrap-around is silent.
- `busy` = state != IDLE.

## Timing
- Reset values: all gnt, `wr_beat_ack`, `mem_wr`, all valids and `busy` = 0; all addresses and data = 0; state IDLE; owner tag none.
- Request sampled in IDLE at cycle N:
  - gnt pulses at N+1.
  - First beat at N+1: burst state is entered at the same edge that asserts gnt, so gnt coincides with beat 0.
- Beat timing:
  - Write beat k occurs at N+1+k.
  - Read data for beat k is valid at N+2+k.
- Burst to burst: one IDLE cycle between consecutive bursts. A trailing read return may overlap the IDLE cycle or the next burst; routing by tag keeps it correct.
- Requests that assert while a burst is running are ignored until IDLE. `disp_urgent` is sampled only in IDLE.
- `rst_n` low mid-burst:
  - Immediately abort the burst and clear the owner tag; no valid is produced for the in-flight read.
  - After release, start in IDLE with pointer at WR.

## Configuration
- `EXT_ARB_PERF_CNT_EN` defined:
  - Adds outputs `perf_busy_cnt[31:0]` (cycles with `busy=1`) and `perf_urgent_cnt[31:0]` (grants won via `disp_urgent`).
  - Both reset to 0 and wrap at 2^32.
- Undefined: those ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then `wr_req`, `wr_addr=0x100`, `wr_len=3`, data 0xA0..0xA3 → `wr_gnt` one cycle; `mem_wr` high 4 cycles at 0x100, 0x104, 0x108, 0x10C; `busy` low after.
- `rd_req`, `rd_addr=0x200`, `rd_len=1` → `mem_rd_addr` 0x200, 0x208; `rd_valid` 2 cycles, lagging by 1; `disp_valid` stays 0.
- `wr_req`, `rd_req`, `disp_req` all held from reset → grant order RD, DISP, WR, RD…; exactly one IDLE cycle between bursts.
- All three requesters pending, pointer at RD, `disp_urgent=1` → `disp_gnt` first; `perf_urgent_cnt`=1 when the macro is defined.
- RD burst of 1 beat followed immediately by a DISP burst → the RD return is not misrouted to `disp_valid`.
- `rst_n` pulsed low during beat 2 of an 8-beat DISP burst → all outputs 0 at once; no further `disp_valid`; the next request is granted normally.
